udp_frame_packer: RTL

- Converts the UDP payload byte stream from the RMII receive path into 16-bit pixel words for the DDR3 frame-buffer write port.
- It feeds wr_en / wr_data / wr_load of ddr_ctrl_top, which carries the 480x360 two-picture image.
- Each UDP packet carries one image line: a 2-byte big-endian line index, then PKT_SIZE pixel pairs, low byte first (byte 0 = picture 0 luma, byte 1 = picture 1 luma).
- The block checks line sequence, keeps frame geometry intact on short packets, and marks the start of each frame.

---
 rtl/udp_frame_packer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/udp_frame_packer.sv
// udp_frame_packer
//   Turns the UDP payload byte stream from the RMII receive path into 16-bit
//   pixel words for the frame-buffer write port. Each packet carries one image
//   line: a big-endian 16-bit line index followed by PKT_SIZE pixel pairs,
//   low byte (picture 0) first. The line sequence is tracked. Short lines are
//   zero-padded so that the frame geometry stays intact. The start of every
//   frame is marked with wr_load.
//
// Ports
//   clk        receive-domain clock
//   rst_n      asynchronous active-low reset
//   in_valid   payload byte valid (no backpressure)
//   in_data    payload byte
//   in_sop     first byte of a payload
//   in_eop     last byte of a payload
//   wr_en      pixel word strobe
//   wr_data    {picture1 byte, picture0 byte}
//   wr_load    one-cycle frame-start pulse (frame buffer address reload)
//   frame_done one-cycle pulse with the last word of line LINES-1
//   locked     line sequence is being tracked
//   err_cnt    saturating protocol error count
//
// State | meaning
//   IDLE  | waiting for a start-of-payload byte (the line index high byte)
//   HDR0  | transient; never held, falls straight back to IDLE
//   HDR1  | waiting for the line index low byte, then checking the line
//   DATA  | collecting pixel byte pairs into words
//   PAD   | emitting zero words to complete a short line
//   DROP  | discarding bytes until end of payload
module udp_frame_packer #(
  parameter int PKT_SIZE = 480,
  parameter int LINES    = 360,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic             wr_en,
  output logic [15:0]      wr_data,
  output logic             wr_load,
  output logic             frame_done,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int             WCW       = $clog2(PKT_SIZE + 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(PKT_SIZE - 1);
  localparam logic [15:0]    LINES_W   = 16'(LINES);
  localparam logic [15:0]    LAST_LINE = 16'(LINES - 1);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, PAD, DROP} state_t;

  state_t             state_q, state_d;
  logic [15:0]        line_q, line_d;
  logic [15:0]        exp_line_q, exp_line_d;
  logic [WCW-1:0]     word_cnt_q, word_cnt_d;
  logic [7:0]         lo_q, lo_d;
  logic               phase_q, phase_d;
  logic               locked_q, locked_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [15:0]        wr_data_q, wr_data_d;
  logic               wr_load_q, wr_load_d;
  logic               frame_done_q, frame_done_d;

  logic               err_inc;
  logic               line_end;
  logic [15:0]        hdr_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      line_q       <= '0;
      exp_line_q   <= '0;
      word_cnt_q   <= '0;
      lo_q         <= '0;
      phase_q      <= 1'b0;
      locked_q     <= 1'b0;
      err_cnt_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      wr_load_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      exp_line_q   <= exp_line_d;
      word_cnt_q   <= word_cnt_d;
      lo_q         <= lo_d;
      phase_q      <= phase_d;
      locked_q     <= locked_d;
      err_cnt_q    <= err_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_load_q    <= wr_load_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    exp_line_d   = exp_line_q;
    word_cnt_d   = word_cnt_q;
    lo_d         = lo_q;
    phase_d      = phase_q;
    locked_d     = locked_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    wr_load_d    = 1'b0;
    frame_done_d = 1'b0;
    err_inc      = 1'b0;
    line_end     = 1'b0;
    hdr_line     = {line_q[15:8], in_data};

    // A new start-of-payload inside a line abandons that line outright;
    // no padding is emitted for it.
    if (in_valid && in_sop &&
        (state_q == HDR1 || state_q == DATA || state_q == PAD || state_q == DROP)) begin
      err_inc  = 1'b1;
      locked_d = 1'b0;
      line_d   = {in_data, 8'h00};
      state_d  = HDR1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_sop) begin
            if (in_eop) begin
              err_inc = 1'b1;
            end else begin
              line_d  = {in_data, 8'h00};
              state_d = HDR1;
            end
          end
        end
        HDR0: state_d = IDLE;
        HDR1: begin
          if (in_valid) begin
            line_d = hdr_line;
            if (in_eop) begin
              err_inc = 1'b1;
              state_d = IDLE;
            end else if (hdr_line >= LINES_W) begin
              err_inc  = 1'b1;
              locked_d = 1'b0;
              state_d  = DROP;
            end else if (hdr_line == 16'd0) begin
              // Line 0 always (re)locks and restarts the frame buffer address.
              wr_load_d  = 1'b1;
              locked_d   = 1'b1;
              word_cnt_d = '0;
              phase_d    = 1'b0;
              state_d    = DATA;
            end else if (locked_q && hdr_line == exp_line_q) begin
              word_cnt_d = '0;
              phase_d    = 1'b0;
              state_d    = DATA;
            end else begin
              // Out-of-sequence lines only count as errors while locked.
              err_inc  = locked_q;
              locked_d = 1'b0;
              state_d  = DROP;
            end
          end
        end
        DATA: begin
          if (in_valid) begin
            if (!phase_q) begin
              lo_d    = in_data;
              phase_d = 1'b1;
              if (in_eop) begin
                // The dangling low byte is dropped; padding fills the line.
                err_inc = 1'b1;
                state_d = PAD;
              end
            end else begin
              wr_en_d    = 1'b1;
              wr_data_d  = {in_data, lo_q};
              phase_d    = 1'b0;
              word_cnt_d = word_cnt_q + WCW'(1);
              if (word_cnt_q == LAST_WORD) begin
                line_end = 1'b1;
                if (in_eop) begin
                  state_d = IDLE;
                end else begin
                  err_inc = 1'b1;
                  state_d = DROP;
                end
              end else if (in_eop) begin
                err_inc = 1'b1;
                state_d = PAD;
              end
            end
          end
        end
        PAD: begin
          wr_en_d    = 1'b1;
          wr_data_d  = '0;
          word_cnt_d = word_cnt_q + WCW'(1);
          if (word_cnt_q == LAST_WORD) begin
            line_end = 1'b1;
            state_d  = IDLE;
          end
        end
        DROP: begin
          if (in_valid && in_eop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (line_end) begin
      frame_done_d = (line_q == LAST_LINE);
      exp_line_d   = (line_q == LAST_LINE) ? 16'd0 : line_q + 16'd1;
    end

    err_cnt_d = (err_inc && err_cnt_q != {ERR_W{1'b1}}) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
  end

  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign wr_load    = wr_load_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign err_cnt    = err_cnt_q;

endmodule
